// File: rtl/cpu_defs.sv
// Shared CPU-side encodings: arbiter owner tags, sram access sizes, arbiter FSM states.
package cpu_defs;
   localparam logic ARB_TAG_INST = 1'b0;
   localparam logic ARB_TAG_DATA = 1'b1;

   localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
   localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;
endpackage

// File: rtl/arb_tag_fifo.sv
// 1-bit synchronous FIFO holding the owner tag of every accepted, unanswered request.
module arb_tag_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push_i,
   input  logic din_i,
   input  logic pop_i,
   output logic dout_o,
   output logic full_o,
   output logic empty_o
);
   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0] tags_q;
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign dout_o  = tags_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointers are PW bits wide, so they wrap at DEPTH (a power of 2) on their own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tags_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            tags_q[wr_ptr_q] <= din_i;
            wr_ptr_q         <= wr_ptr_q + PW'(1);
         end
         if (do_pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         if (do_push && !do_pop)
            count_q <= count_q + (PW+1)'(1);
         else if (do_pop && !do_push)
            count_q <= count_q - (PW+1)'(1);
      end
   end
endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between inst_sram and data_sram; grant is locked until
// addr_ok and in-order responses are routed back via an owner-tag FIFO.
module sram_like_arbiter
   import cpu_defs::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_req,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_e    state_q, state_d;
   logic          owner_q, owner_d;
   logic [SW-1:0] starve_q, starve_d;

   logic inst_force, win_data, sel_any, sel_data, accept;
   logic fifo_full, fifo_empty, head_tag, pop;

   // Once locked, the owner keeps the port even if the other master wins priority.
   always_comb begin
      inst_force = inst_sram_req && (starve_q == SW'(STARVE_LIMIT));
      win_data   = data_sram_req && !inst_force;
      sel_any    = win_data || inst_sram_req;
      sel_data   = win_data;
      if (state_q == ARB_LOCKED) begin
         sel_any  = 1'b1;
         sel_data = (owner_q == ARB_TAG_DATA);
      end
   end

   assign mem_req = sel_any && !fifo_full;
   assign accept  = mem_req && mem_addr_ok;

   always_comb begin
      mem_wr    = 1'b0;
      mem_size  = 2'b00;
      mem_wstrb = 4'b0000;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      if (sel_any && sel_data) begin
         mem_wr    = data_sram_wr;
         mem_size  = data_sram_size;
         mem_wstrb = data_sram_wstrb;
         mem_addr  = data_sram_addr;
         mem_wdata = data_sram_wdata;
      end else if (sel_any) begin
         mem_size  = inst_sram_size;
         mem_addr  = inst_sram_addr;
      end
   end

   assign inst_sram_addr_ok = accept && !sel_data;
   assign data_sram_addr_ok = accept && sel_data;

   arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (accept),
      .din_i   (sel_data ? ARB_TAG_DATA : ARB_TAG_INST),
      .pop_i   (pop),
      .dout_o  (head_tag),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // A response with nothing outstanding is dropped rather than popped.
   assign pop               = mem_data_ok && !fifo_empty;
   assign inst_sram_data_ok = pop && (head_tag == ARB_TAG_INST);
   assign data_sram_data_ok = pop && (head_tag == ARB_TAG_DATA);
   assign inst_sram_rdata   = inst_sram_data_ok ? mem_rdata : 32'h0;
   assign data_sram_rdata   = data_sram_data_ok ? mem_rdata : 32'h0;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         ARB_IDLE:
            if (mem_req && !mem_addr_ok) begin
               state_d = ARB_LOCKED;
               owner_d = sel_data ? ARB_TAG_DATA : ARB_TAG_INST;
            end
         ARB_LOCKED:
            if (accept) state_d = ARB_IDLE;
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      starve_d = starve_q;
      if (!inst_sram_req || inst_sram_addr_ok)
         starve_d = '0;
      else if (data_sram_addr_ok && (starve_q != SW'(STARVE_LIMIT)))
         starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         owner_q  <= ARB_TAG_INST;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   always @(posedge clk) begin
      if (!reset)
         assert (!(mem_data_ok && fifo_empty))
            else $error("sram_like_arbiter: mem_data_ok with no outstanding request");
   end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: priority, lock, starvation, full FIFO, routing, reset.
module tb_sram_like_arbiter;
   import cpu_defs::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   sram_like_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
      .clk (clk), .reset (reset),
      .inst_sram_req (inst_sram_req), .inst_sram_size (inst_sram_size),
      .inst_sram_addr (inst_sram_addr), .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok), .inst_sram_rdata (inst_sram_rdata),
      .data_sram_req (data_sram_req), .data_sram_wr (data_sram_wr),
      .data_sram_size (data_sram_size), .data_sram_wstrb (data_sram_wstrb),
      .data_sram_addr (data_sram_addr), .data_sram_wdata (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok), .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata (data_sram_rdata),
      .mem_req (mem_req), .mem_wr (mem_wr), .mem_size (mem_size), .mem_wstrb (mem_wstrb),
      .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_addr_ok (mem_addr_ok),
      .mem_data_ok (mem_data_ok), .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
         else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   task automatic idle();
      inst_sram_req   = 1'b0;
      inst_sram_size  = SRAM_SIZE_WORD;
      inst_sram_addr  = 32'h0;
      data_sram_req   = 1'b0;
      data_sram_wr    = 1'b0;
      data_sram_size  = 2'b00;
      data_sram_wstrb = 4'h0;
      data_sram_addr  = 32'h0;
      data_sram_wdata = 32'h0;
      mem_addr_ok     = 1'b0;
      mem_data_ok     = 1'b0;
      mem_rdata       = 32'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_i, prev_i;
      prev_i = 1'b0;
      reset = 1'b1;
      idle();
      #2;
      chk("rst_mem_req",  mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_i_aok",    inst_sram_addr_ok, 0);
      chk("rst_d_dok",    data_sram_data_ok, 0);
      chk("rst_i_rdata",  inst_sram_rdata, 0);
      tick();
      reset = 1'b0;

      // inst only: accept at t0, response at t2
      tick(); inst_sram_req = 1; inst_sram_addr = 32'h1c000000; mem_addr_ok = 1; #1;
      chk("t1_mem_req",  mem_req, 1);
      chk("t1_mem_addr", mem_addr, 32'h1c000000);
      chk("t1_mem_wr",   mem_wr, 0);
      chk("t1_i_aok",    inst_sram_addr_ok, 1);
      chk("t1_d_aok",    data_sram_addr_ok, 0);
      tick(); idle(); #1;
      chk("t1_t1_req",   mem_req, 0);
      chk("t1_t1_i_dok", inst_sram_data_ok, 0);
      tick(); mem_data_ok = 1; mem_rdata = 32'hdeadbeef; #1;
      chk("t1_i_dok",    inst_sram_data_ok, 1);
      chk("t1_i_rdata",  inst_sram_rdata, 32'hdeadbeef);
      chk("t1_d_dok",    data_sram_data_ok, 0);
      chk("t1_d_rdata",  data_sram_rdata, 0);

      // both request: data wins, 2-cycle addr_ok stall
      tick(); idle();
      inst_sram_req = 1; inst_sram_addr = 32'h1c000004;
      data_sram_req = 1; data_sram_wr = 1; data_sram_size = SRAM_SIZE_WORD;
      data_sram_wstrb = 4'hf; data_sram_addr = 32'h80001000; data_sram_wdata = 32'h12345678; #1;
      chk("t2_mem_req",   mem_req, 1);
      chk("t2_mem_wr",    mem_wr, 1);
      chk("t2_mem_addr",  mem_addr, 32'h80001000);
      chk("t2_mem_wdata", mem_wdata, 32'h12345678);
      chk("t2_mem_wstrb", mem_wstrb, 4'hf);
      chk("t2_d_aok0",    data_sram_addr_ok, 0);
      tick(); #1;
      chk("t2_stall_addr", mem_addr, 32'h80001000);
      tick(); mem_addr_ok = 1; #1;
      chk("t2_d_aok", data_sram_addr_ok, 1);
      chk("t2_i_aok", inst_sram_addr_ok, 0);
      tick(); data_sram_req = 0; #1;
      chk("t2_i_aok2",   inst_sram_addr_ok, 1);
      chk("t2_i_addr",   mem_addr, 32'h1c000004);
      chk("t2_i_wr",     mem_wr, 0);
      tick(); idle(); mem_data_ok = 1; mem_rdata = 32'ha1; #1;
      chk("t2_d_dok",    data_sram_data_ok, 1);
      chk("t2_d_rdata",  data_sram_rdata, 32'ha1);
      chk("t2_i_dok0",   inst_sram_data_ok, 0);
      tick(); mem_rdata = 32'ha2; #1;
      chk("t2_i_dok",    inst_sram_data_ok, 1);
      chk("t2_i_rdata",  inst_sram_rdata, 32'ha2);

      // lock on inst holds against a later data req; then I,D,I routed in order
      tick(); idle(); inst_sram_req = 1; inst_sram_addr = 32'h1c000010;
      tick(); data_sram_req = 1; data_sram_addr = 32'h00002000; #1;
      chk("t5_lock_addr", mem_addr, 32'h1c000010);
      chk("t5_lock_wr",   mem_wr, 0);
      tick(); mem_addr_ok = 1; #1;
      chk("t5_lock_i_aok", inst_sram_addr_ok, 1);
      chk("t5_lock_d_aok", data_sram_addr_ok, 0);
      tick(); inst_sram_req = 0; #1;
      chk("t5_d_aok",  data_sram_addr_ok, 1);
      chk("t5_d_addr", mem_addr, 32'h00002000);
      tick(); data_sram_req = 0; inst_sram_req = 1; inst_sram_addr = 32'h1c000014; #1;
      chk("t5_i2_aok", inst_sram_addr_ok, 1);
      tick(); idle(); mem_data_ok = 1; mem_rdata = 32'hb1; #1;
      chk("t5_r1_i", inst_sram_rdata, 32'hb1);
      chk("t5_r1_d", data_sram_data_ok, 0);
      tick(); mem_rdata = 32'hb2; #1;
      chk("t5_r2_d", data_sram_rdata, 32'hb2);
      chk("t5_r2_i", inst_sram_data_ok, 0);
      tick(); mem_rdata = 32'hb3; #1;
      chk("t5_r3_i", inst_sram_rdata, 32'hb3);
      chk("t5_r3_d", data_sram_data_ok, 0);

      // starvation: D,D,D,I,D,D,D,I with a response (pop+push) every cycle
      for (int i = 0; i < 8; i++) begin
         tick(); idle();
         inst_sram_req = 1; inst_sram_addr = 32'h1c000100;
         data_sram_req = 1; data_sram_addr = 32'h00003000;
         mem_addr_ok = 1; mem_data_ok = (i > 0); mem_rdata = 32'(i); #1;
         exp_i = (i == 3) || (i == 7);
         chk($sformatf("t3_i_aok%0d", i), inst_sram_addr_ok, exp_i);
         chk($sformatf("t3_d_aok%0d", i), data_sram_addr_ok, !exp_i);
         if (i > 0) begin
            chk($sformatf("t3_i_dok%0d", i), inst_sram_data_ok, prev_i);
            chk($sformatf("t3_d_dok%0d", i), data_sram_data_ok, !prev_i);
         end
         prev_i = exp_i;
      end
      tick(); idle(); mem_data_ok = 1; mem_rdata = 32'h77; #1;
      chk("t3_last_i_dok", inst_sram_data_ok, 1);
      chk("t3_last_rdata", inst_sram_rdata, 32'h77);

      // full FIFO blocks mem_req until one response frees a slot
      for (int i = 0; i < 4; i++) begin
         tick(); idle(); data_sram_req = 1; data_sram_addr = 32'h4000 + 32'(4 * i); mem_addr_ok = 1; #1;
         chk($sformatf("t4_aok%0d", i), data_sram_addr_ok, 1);
      end
      tick(); #1;
      chk("t4_full_req", mem_req, 0);
      chk("t4_full_aok", data_sram_addr_ok, 0);
      tick(); mem_data_ok = 1; mem_rdata = 32'h44; #1;
      chk("t4_pop_req", mem_req, 0);
      chk("t4_pop_dok", data_sram_data_ok, 1);
      tick(); mem_data_ok = 0; #1;
      chk("t4_again_req", mem_req, 1);
      chk("t4_again_aok", data_sram_addr_ok, 1);
      for (int i = 0; i < 4; i++) begin
         tick(); idle(); mem_data_ok = 1; #1;
         chk($sformatf("t4_drain%0d", i), data_sram_data_ok, 1);
      end

      // reset while locked with two outstanding
      tick(); idle(); inst_sram_req = 1; inst_sram_addr = 32'h1c000200; mem_addr_ok = 1;
      tick(); inst_sram_req = 0; data_sram_req = 1;
      tick(); data_sram_req = 0; inst_sram_req = 1; mem_addr_ok = 0;
      tick(); #1;
      chk("t6_locked_req", mem_req, 1);
      reset = 1; idle(); #1;
      chk("t6_rst_req",   mem_req, 0);
      chk("t6_rst_addr",  mem_addr, 0);
      chk("t6_rst_i_aok", inst_sram_addr_ok, 0);
      chk("t6_rst_i_dok", inst_sram_data_ok, 0);
      tick(); reset = 0;
      for (int i = 0; i < 4; i++) begin
         tick(); idle(); inst_sram_req = 1; inst_sram_addr = 32'h1c000300; mem_addr_ok = 1; #1;
         chk($sformatf("t6_aok%0d", i), inst_sram_addr_ok, 1);
      end
      tick(); #1;
      chk("t6_full_req", mem_req, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); idle(); mem_data_ok = 1; mem_rdata = 32'hc0 + 32'(i); #1;
         chk($sformatf("t6_dok%0d", i), inst_sram_rdata, 32'hc0 + 32'(i));
      end
      tick(); idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
